// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states, cause codes,
// default vector-table addresses and the PC-mux select used while loading the handler.
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_READ = 3'd2,
        ST_LOAD = 3'd3,
        ST_DONE = 3'd4
    } exc_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_OPCODE = 2'd1,
        CAUSE_OVF    = 2'd2,
        CAUSE_DIV0   = 2'd3
    } exc_cause_e;

    localparam logic [31:0] VEC_OPCODE_DEF = 32'd253;
    localparam logic [31:0] VEC_OVF_DEF    = 32'd254;
    localparam logic [31:0] VEC_DIV0_DEF   = 32'd255;
    localparam logic [3:0]  PCSEL_EXC      = 4'd8;
    localparam logic [31:0] EPC_OFFSET     = 32'd4;

    // Fixed priority: opcode > overflow > div0; lower causes are dropped.
    function automatic exc_cause_e pick_cause(input logic op, input logic ovf, input logic dv);
        if (op)
            return CAUSE_OPCODE;
        else if (ovf)
            return CAUSE_OVF;
        else if (dv)
            return CAUSE_DIV0;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// Loadable saturating down-counter timing the memory read wait.
// o_zero is high in the cycle whose decrement brings the count to zero.
module exc_wait_counter #(
    parameter int CW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && (r_count != '0))
            r_count <= r_count - CW'(1);
    end

    assign o_zero = (r_count <= CW'(1));

endmodule

// File: rtl/exception_controller.sv
// Exception entry sequencer: stalls main control, saves EPC, fetches the one-byte
// handler address from the vector table and loads it into PC through the PC mux.
module exception_controller
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
    parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
    parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF,
    parameter int          MEM_LAT    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        epc_wr,
    output logic [31:0] epc_data,
    output logic        pc_wr,
    output logic [3:0]  pc_sel,
    output logic [31:0] pc_value,
    output logic [1:0]  cause,
    output logic        busy,
    output logic        done,
    output exc_state_e  dbg_state
);

    localparam int CW = $clog2(MEM_LAT + 1);

    exc_state_e  r_state;
    exc_cause_e  r_cause;
    logic [31:0] r_pc;
    logic [7:0]  r_vector;
    logic        w_req;
    logic        w_zero;
    logic [31:0] w_vec_addr;

    assign w_req = exc_opcode | exc_overflow | exc_div0;

    // The counter reloads in SAVE so it holds MEM_LAT on the first READ cycle.
    exc_wait_counter #(.CW(CW)) u_wait (
        .clock      (clock),
        .reset      (reset),
        .i_load     (r_state == ST_SAVE),
        .i_load_val (CW'(MEM_LAT)),
        .i_en       (r_state == ST_READ),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cause  <= CAUSE_NONE;
            r_pc     <= '0;
            r_vector <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_cause <= pick_cause(exc_opcode, exc_overflow, exc_div0);
                        r_pc    <= pc_in;
                        r_state <= ST_SAVE;
                    end
                end
                ST_SAVE: r_state <= ST_READ;
                ST_READ: begin
                    if (w_zero) begin
                        r_vector <= mem_data;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: r_state <= ST_DONE;
                ST_DONE: begin
                    r_cause <= CAUSE_NONE;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_cause)
            CAUSE_OPCODE: w_vec_addr = VEC_OPCODE;
            CAUSE_OVF:    w_vec_addr = VEC_OVF;
            CAUSE_DIV0:   w_vec_addr = VEC_DIV0;
            default:      w_vec_addr = '0;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        mem_rd   = 1'b0;
        epc_wr   = 1'b0;
        epc_data = '0;
        pc_wr    = 1'b0;
        pc_sel   = '0;
        pc_value = '0;
        done     = 1'b0;
        case (r_state)
            ST_SAVE: begin
                epc_wr   = 1'b1;
                epc_data = r_pc - EPC_OFFSET;
                mem_rd   = 1'b1;
                mem_addr = w_vec_addr;
            end
            ST_READ: begin
                mem_rd   = 1'b1;
                mem_addr = w_vec_addr;
            end
            ST_LOAD: begin
                pc_wr    = 1'b1;
                pc_sel   = PCSEL_EXC;
                pc_value = {24'b0, r_vector};
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign cause     = r_cause;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: directed scenarios then random requests, every cycle
// compared against a timeline model of the exception entry sequence.
module tb_exception_controller;
    import exc_pkg::*;

    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        exc_opcode = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [31:0] pc_in = '0;
    logic [7:0]  mem_data = '0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        epc_wr;
    logic [31:0] epc_data;
    logic        pc_wr;
    logic [3:0]  pc_sel;
    logic [31:0] pc_value;
    logic [1:0]  cause;
    logic        busy;
    logic        done;
    exc_state_e  dbg_state;

    always #5 clock = ~clock;

    exception_controller #(.MEM_LAT(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .pc_in        (pc_in),
        .mem_data     (mem_data),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .epc_wr       (epc_wr),
        .epc_data     (epc_data),
        .pc_wr        (pc_wr),
        .pc_sel       (pc_sel),
        .pc_value     (pc_value),
        .cause        (cause),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    logic [7:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;
    bit scramble = 1'b0;

    // Model: m_k is the cycle number within a sequence (0 = idle, 1 = SAVE, ... L+3 = DONE).
    int          m_k = 0;
    int          m_cause = 0;
    logic [31:0] m_pc = '0;
    logic [7:0]  m_vec = '0;
    int          n_epc = 0;
    int          n_done = 0;
    int          n_pcwr = 0;
    int          cyc = 0;
    int          last_done = -100;
    int          gap_seen = 0;

    function automatic logic [31:0] vec_of(input int c);
        case (c)
            1: return 32'd253;
            2: return 32'd254;
            3: return 32'd255;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic op, input logic ovf, input logic dv,
                        input logic [31:0] pc);
        reset = rst;
        exc_opcode = op;
        exc_overflow = ovf;
        exc_div0 = dv;
        pc_in = pc;
        @(posedge clock);
        cyc++;
        if (rst) begin
            m_k = 0; m_cause = 0; m_pc = '0; m_vec = '0;
        end else if (m_k == 0) begin
            if (op | ovf | dv) begin
                m_k = 1;
                m_cause = op ? 1 : (ovf ? 2 : 3);
                m_pc = pc;
            end
        end else if (m_k == L + 3) begin
            m_k = 0;
            m_cause = 0;
        end else begin
            if (m_k == L + 1) m_vec = mem_data;
            m_k++;
        end
        #1;
        check("busy", 32'(busy), 32'(m_k != 0));
        check("cause", 32'(cause), 32'(m_cause));
        check("epc_wr", 32'(epc_wr), 32'(m_k == 1));
        check("epc_data", epc_data, (m_k == 1) ? m_pc - 32'd4 : 32'd0);
        check("mem_rd", 32'(mem_rd), 32'(m_k >= 1 && m_k <= L + 1));
        check("mem_addr", mem_addr, (m_k >= 1 && m_k <= L + 1) ? vec_of(m_cause) : 32'd0);
        check("pc_wr", 32'(pc_wr), 32'(m_k == L + 2));
        check("pc_sel", 32'(pc_sel), (m_k == L + 2) ? 32'd8 : 32'd0);
        check("pc_value", pc_value, (m_k == L + 2) ? {24'b0, m_vec} : 32'd0);
        check("done", 32'(done), 32'(m_k == L + 3));
        if (epc_wr) begin
            n_epc++;
            if (last_done == cyc - 2) gap_seen++;
        end
        if (done) begin
            n_done++;
            last_done = cyc;
        end
        if (pc_wr) n_pcwr++;
        if (scramble)
            for (int a = 253; a <= 255; a++) mem[a] = 8'($urandom);
        mem_data = mem[mem_addr[7:0]];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'($urandom));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234);
        check("reset_busy", 32'(busy), 32'd0);
        idle(2);

        // Overflow at pc 0x10, handler byte 0x8C
        mem[254] = 8'h8C;
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h10);
        check("s1_epc_data", epc_data, 32'h0000_000C);
        check("s1_mem_addr", mem_addr, 32'd254);
        for (int c = 2; c <= 5; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, '0);
            if (c == 4) begin
                check("s1_pc_value", pc_value, 32'h0000_008C);
                check("s1_pc_sel", 32'(pc_sel), 32'd8);
            end
            if (c == 5) check("s1_done", 32'(done), 32'd1);
        end
        idle(2);

        // Opcode and div0 together: opcode wins
        mem[253] = 8'h40;
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        check("s2_cause", 32'(cause), 32'd1);
        check("s2_mem_addr", mem_addr, 32'd253);
        idle(3);
        check("s2_pc_value", pc_value, 32'h40);
        idle(3);

        // Div0 at pc 0: EPC wraps
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("s3_epc_data", epc_data, 32'hFFFF_FFFC);
        check("s3_mem_addr", mem_addr, 32'd255);
        idle(6);

        // Second overflow pulse during READ is ignored
        n_epc = 0; n_done = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
        idle(8);
        check("s4_epc_count", 32'(n_epc), 32'd1);
        check("s4_done_count", 32'(n_done), 32'd1);

        // Reset during the first READ cycle cancels everything
        n_pcwr = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h400);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_mem_rd", 32'(mem_rd), 32'd0);
        idle(6);
        check("s5_pc_wr_count", 32'(n_pcwr), 32'd0);

        // Overflow held: back-to-back sequences with one idle cycle between
        gap_seen = 0;
        for (int i = 0; i < 3 * (L + 4); i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h800 + 32'(i));
        check("s6_gaps", 32'(gap_seen), 32'd2);
        idle(6);

        // Random traffic with the vector table changing every cycle
        scramble = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0),
                 32'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_controller.md
# exception_controller

Multicycle sequencer that takes the CPU from a detected exception (invalid opcode, arithmetic overflow, divide-by-zero) to the first fetch of its handler. It stalls the main control unit, writes the faulting PC into EPC, reads the one-byte handler address from the exception vector table in memory, and loads it into PC through the PC-source multiplexer. It sits beside the main control unit and drives that multiplexer's 4-bit select only while it owns the datapath.

## Interface
- VEC_OPCODE, 253: byte address of the invalid-opcode vector entry
- VEC_OVF, 254: byte address of the overflow vector entry
- VEC_DIV0, 255: byte address of the divide-by-zero vector entry
- MEM_LAT, 2: memory read latency in cycles, ≥1
- PCSEL_EXC, 4'd8: PC-mux select code that routes `pc_value` to PC
- clock  in  1  system clock, rising edge; the only clock
- reset  in  1  synchronous, active-high
- exc_opcode  in  1  invalid-opcode request, level
- exc_overflow  in  1  overflow request, level
- exc_div0  in  1  divide-by-zero request, level
- pc_in  in  32  current PC, already incremented by 4
- mem_data  in  8  byte returned by memory
- mem_addr  out  32  vector table address
- mem_rd  out  1  memory read strobe
- epc_wr  out  1  EPC write enable
- epc_data  out  32  value written to EPC
- pc_wr  out  1  PC write enable
- pc_sel  out  4  PC-mux select
- pc_value  out  32  zero-extended handler address
- cause  out  2  latched cause: 0 none, 1 opcode, 2 overflow, 3 div0
- busy  out  1  main control must hold
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SAVE, READ, LOAD, DONE. All outputs are Moore outputs decoded from registered state and registers.
- IDLE: all outputs 0. If any request is high at a rising edge, the block:
  - latches `cause` by fixed priority: opcode > overflow > div0;
  - latches `pc_in`;
  - goes to SAVE.
- SAVE, one cycle:
  - `epc_wr`=1 and `epc_data` = latched PC − 4, modulo 2^32, so 0 gives 0xFFFF_FFFC;
  - `mem_rd`=1 and `mem_addr` = vector for `cause`.
- READ, MEM_LAT cycles, counted by a wait counter:
  - `mem_rd` and `mem_addr` stay held;
  - on the edge that ends the last READ cycle, `mem_data` is captured into an 8-bit vector register.
- LOAD, one cycle: `pc_wr`=1, `pc_sel`=PCSEL_EXC, `pc_value` = {24'b0, vector}.
- DONE, one cycle: `done`=1. Next state is IDLE and `cause` is cleared.
- `busy`=1 in every state except IDLE.
- Requests arriving while not in IDLE are ignored, not queued. Requests still high in the cycle after DONE start a new sequence.
- `pc_sel`=0 outside LOAD, so the main control owns the mux encoding.

## Timing
- Edge 0 accepts the request. The following cycles are:
  - cycle 1: SAVE;
  - cycles 2..1+MEM_LAT: READ;
  - cycle 2+MEM_LAT: LOAD;
  - cycle 3+MEM_LAT: DONE.
- Total latency is MEM_LAT+3 cycles. `pc_wr` takes effect at the end of LOAD.
- Reset, at any state and any cycle: next state IDLE; counter, `cause`, latched PC and vector register cleared; every output 0 in the following cycle. A PC write in progress is cancelled unless LOAD has already completed.
- Simultaneous requests: only the highest-priority cause is serviced; the rest are dropped.
- The wait counter is width clog2(MEM_LAT+1) and never wraps. It reloads on entry to READ.

## Structure
- Shared package `exc_pkg`:
  - state enum;
  - 2-bit cause codes;
  - default vector addresses;
  - PCSEL_EXC;
  - EPC offset constant 4.
- One sub-module is natural: `exc_wait_counter`, a loadable down-counter. Its inputs are load value MEM_LAT and an enable; its output is `zero`. READ exits on `zero`.

## Test plan
- Overflow with `pc_in`=0x0000_0010, byte 0x8C at address 254, MEM_LAT=2 -> SAVE cycle has `epc_data`=0x0000_000C and `mem_addr`=254; LOAD in cycle 4 has `pc_value`=0x0000_008C and `pc_sel`=8; `done` in cycle 5.
- `exc_opcode` and `exc_div0` high together, byte 0x40 at address 253 -> `cause`=1, `mem_addr`=253, `pc_value`=0x40.
- `pc_in`=0 with a div0 request -> `epc_data`=0xFFFF_FFFC and `mem_addr`=255.
- A second overflow pulse during READ -> ignored: exactly one `epc_wr` and one `done` pulse.
- Reset asserted in the first READ cycle -> next cycle all outputs 0 and `busy`=0; no `pc_wr` ever asserted.
- `exc_overflow` held high continuously -> back-to-back sequences with exactly one IDLE cycle between a DONE and the next SAVE.
